// File: rtl/tdc_readout_seq.sv
// ---------------------------------------------------------------------------
// tdc_readout_seq
//   Measurement sequencer and readout master for the TDC core. Issues the
//   start/stop stimulus with a programmable stop offset, waits for the TDC to
//   settle, walks the 2-bit byte select of the TDC output mux to rebuild a
//   32-bit time count, and hands the word downstream over valid/ready.
//
// Parameters
//   SETTLE_CYCLES  cycles from tdc_stop rising to the first byte select (1..255)
//   BYTE_WAIT      cycles each select value is held before sampling  (1..15)
//
// Ports
//   clk, rst_n     clock (rising edge) / asynchronous active-low reset
//   trig           measurement request, honoured only while idle
//   delay          stop offset in cycles, captured with trig (0 behaves as 1)
//   busy           high whenever the sequencer is not idle
//   tdc_start      TDC start stimulus
//   tdc_stop       TDC stop stimulus
//   tdc_sel        TDC byte select (0 = bits [7:0] .. 3 = bits [31:24])
//   tdc_byte       byte returned by the TDC for the current select
//   word           assembled 32-bit count
//   word_valid     word is available
//   word_ready     consumer accepts word
//   trig_drop      sticky flag: trig seen while busy; cleared only by reset
// ---------------------------------------------------------------------------
module tdc_readout_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned BYTE_WAIT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [7:0]  delay,
  output logic        busy,
  output logic        tdc_start,
  output logic        tdc_stop,
  output logic [1:0]  tdc_sel,
  input  logic [7:0]  tdc_byte,
  output logic [31:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        trig_drop
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(BYTE_WAIT);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    dly_cnt;
  logic [CNT_W-1:0]    settle_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    byte_idx;

  // Sequencer: every counter is loaded with its length on state entry and the
  // state advances on the edge where it reads 1, so a load of N spans N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dly_cnt    <= '0;
      settle_cnt <= '0;
      wait_cnt   <= '0;
      byte_idx   <= '0;
      busy       <= 1'b0;
      tdc_start  <= 1'b0;
      tdc_stop   <= 1'b0;
      tdc_sel    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      trig_drop  <= 1'b0;
    end else begin
      // Any request arriving while busy is lost; remember that it happened.
      if (busy && trig) begin
        trig_drop <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trig) begin
            state     <= ST_DELAY;
            busy      <= 1'b1;
            tdc_start <= 1'b1;
            dly_cnt   <= (delay == '0) ? CNT_ONE : delay;
          end
        end

        ST_DELAY: begin
          if (dly_cnt <= CNT_ONE) begin
            state      <= ST_SETTLE;
            tdc_stop   <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            dly_cnt <= dly_cnt - CNT_ONE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt <= CNT_ONE) begin
            state    <= ST_READ;
            tdc_sel  <= '0;
            byte_idx <= '0;
            wait_cnt <= WAIT_LOAD;
          end else begin
            settle_cnt <= settle_cnt - CNT_ONE;
          end
        end

        ST_READ: begin
          if (wait_cnt <= WAIT_ONE) begin
            // Last cycle of the select window: the mux output has had the
            // whole window to settle, so capture it now.
            case (byte_idx)
              2'd0:    word[7:0]   <= tdc_byte;
              2'd1:    word[15:8]  <= tdc_byte;
              2'd2:    word[23:16] <= tdc_byte;
              default: word[31:24] <= tdc_byte;
            endcase
            if (byte_idx == IDX_LAST) begin
              state      <= ST_HOLD;
              tdc_start  <= 1'b0;
              tdc_stop   <= 1'b0;
              tdc_sel    <= '0;
              byte_idx   <= '0;
              word_valid <= 1'b1;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              tdc_sel  <= byte_idx + IDX_W'(1);
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_ONE;
          end
        end

        ST_HOLD: begin
          if (word_ready) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            word_valid <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          tdc_start  <= 1'b0;
          tdc_stop   <= 1'b0;
          tdc_sel    <= '0;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tdc_readout_seq.md
# tdc_readout_seq

Measurement sequencer and readout master for the TDC core. It generates the `start`/`stop` stimulus the TDC consumes, with the stop offset programmable in clock cycles. After a settle window it walks the 2-bit byte-select of the TDC's 8-bit output mux and reassembles the 32-bit time count. The word is presented to downstream logic over a valid/ready handshake.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles between `tdc_stop` rising and the first mux select; range 1..255.
- `BYTE_WAIT`, default 2: cycles each select value is held before its byte is sampled; range 1..15.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `trig` in 1: measurement request, sampled only in IDLE.
- `delay` in 8: stop offset in cycles, captured on accepted `trig`; 0 treated as 1.
- `busy` out 1: high whenever state is not IDLE.
- `tdc_start` out 1: to TDC start input.
- `tdc_stop` out 1: to TDC stop input.
- `tdc_sel` out 2: to TDC byte select; 0 = bits [7:0] … 3 = bits [31:24].
- `tdc_byte` in 8: selected TDC byte.
- `word` out 32: assembled count.
- `word_valid` out 1: `word` available.
- `word_ready` in 1: consumer accepts `word`.
- `trig_drop` out 1: sticky, set when `trig`=1 while `busy`=1; cleared only by reset.

## Operation
- All outputs are registered.
- Reset value of every output: `busy`, `tdc_start`, `tdc_stop`, `tdc_sel`, `word`, `word_valid`, and `trig_drop` are all 0. Reset mid-operation aborts immediately (asynchronous), and the block returns to IDLE.
- States:
  - IDLE: waits for `trig`.
  - DELAY: `tdc_start`=1 and a counter runs D_eff = max(`delay`,1) cycles.
  - SETTLE: `tdc_start`=`tdc_stop`=1 for `SETTLE_CYCLES` cycles.
  - READ: `tdc_start`=`tdc_stop`=1. For k = 0..3, `tdc_sel`=k for `BYTE_WAIT` cycles; on the last cycle of each window, `tdc_byte` is written into `word[8k+7:8k]`.
  - HOLD: `tdc_start`=`tdc_stop`=0, `tdc_sel`=0, `word_valid`=1.
- Transitions: IDLE→DELAY on `trig`; DELAY→SETTLE on counter expiry; SETTLE→READ on expiry; READ→HOLD after byte 3 is sampled; HOLD→IDLE on `word_ready`.
- `tdc_sel` is 0 in every state except READ.
- `word` is stable throughout HOLD. It keeps its last value in IDLE and is overwritten byte by byte in the next READ.
- `trig` outside IDLE is ignored for sequencing but sets `trig_drop`. This includes `trig` in the same cycle as the HOLD→IDLE transition.
- Width rules:
  - The `delay` counter is 8 bits.
  - The settle counter is 8 bits.
  - The byte-wait counter is 4 bits.
  - The byte index is 2 bits and wraps 3→0 only on HOLD entry.
  - No arithmetic is performed on the assembled word.

## Timing
Let trig=1 be sampled in IDLE at edge T, with D=D_eff, S=`SETTLE_CYCLES`, B=`BYTE_WAIT`.
- `busy` and `tdc_start` rise at T+1.
- `tdc_stop` rises at T+1+D.
- `tdc_sel`=0 from T+1+D+S, then changes to k at T+1+D+S+kB.
- Byte k is sampled at edge T+D+S+(k+1)B.
- `word_valid` rises, and `tdc_start`/`tdc_stop` fall, at T+1+D+S+4B.
- If `word_ready`=1 at the first HOLD edge, `word_valid` lasts exactly one cycle, and `busy` falls with it.
- Back-to-back operation: the earliest next `trig` is accepted the cycle after `busy` falls.
- Minimum measurement-to-valid latency: D=1, S=1, B=1 gives 7 cycles.
- `word_ready` is ignored outside HOLD.

## Test plan
- Basic run:
  - Stimulus: reset release; defaults S=4, B=2; `delay`=5; pulse `trig` at T; TDC model returns 0x11, 0x22, 0x33, 0x44 for sel 0..3; `word_ready`=1.
  - Required response: `tdc_stop` rises at T+6; `word_valid` at T+18 for exactly one cycle; `word`=0x44332211.
- Zero delay:
  - Stimulus: `delay`=0.
  - Required response: `tdc_stop` rises at T+2, identical to `delay`=1; `word_valid` at T+14.
- Backpressure:
  - Stimulus: `word_ready`=0 for 10 cycles after `word_valid`; change `tdc_byte` during HOLD.
  - Required response: `word` and `word_valid` stay constant; `tdc_sel`=0; `busy`=1; release gives IDLE one cycle later.
- Dropped trigger:
  - Stimulus: `trig` pulse during DELAY and during HOLD.
  - Required response: no extra measurement starts; `trig_drop`=1 and stays 1 until `rst_n` is asserted.
- Reset mid-READ:
  - Stimulus: assert `rst_n`=0 while `tdc_sel`=2.
  - Required response: all outputs 0 without waiting for a clock edge; after release, a fresh `trig` yields a correct word.
- Sampling alignment:
  - Stimulus: B=3; the TDC model changes its byte on the first cycle of each select window.
  - Required response: each byte is captured from the last cycle of its window, with no byte from the previous select.
